// File: rtl/pid_param_loader.sv
// Framed, checksummed byte-command parser feeding a bank of PID parameter registers,
// with ACK/NAK/read-back responses, inter-byte timeout and a saturating error counter.
module pid_param_loader #(
    parameter int              NUM_REGS  = 4,
    parameter int              WIDTH     = 16,
    parameter int              TIMEOUT   = 100000,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic                      data_rdy,
    input  logic [7:0]                data_in,
    output logic [7:0]                tx_byte,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [NUM_REGS*WIDTH-1:0] regs,
    output logic                      update_pulse,
    output logic [6:0]                wr_addr,
    output logic [7:0]                err_count
);
    localparam int BYTES = WIDTH / 8;
    localparam int BW    = $clog2(BYTES + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [7:0] SOF = 8'hA5;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_CHK, S_RESP} state_e;
    state_e state_q, state_d;

    logic [6:0]                     addr_q;
    logic                           rd_q;
    logic [7:0]                     chk_q;
    logic [WIDTH-1:0]               data_q;
    logic [BW-1:0]                  dcnt_q;
    logic [TW-1:0]                  tmo_q;
    logic                           exec_q;
    logic                           ok_q;
    logic [WIDTH-1:0]               resp_q;
    logic [BW-1:0]                  rem_q;
    logic [NUM_REGS-1:0][WIDTH-1:0] regs_q;
    logic [7:0]                     tx_byte_q;
    logic                           tx_valid_q;
    logic                           upd_q;
    logic [6:0]                     wr_addr_q;
    logic [7:0]                     err_q;

    logic in_frame, timeout, tx_done, addr_ok, err_inc;

    assign in_frame = (state_q == S_CMD) || (state_q == S_DATA) || (state_q == S_CHK);
    assign timeout  = in_frame && !data_rdy && (tmo_q == TW'(TIMEOUT - 1));
    assign tx_done  = tx_valid_q && tx_ready && (rem_q == '0) && !exec_q;
    assign addr_ok  = int'(addr_q) < NUM_REGS;
    assign err_inc  = timeout || (exec_q && !ok_q);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (data_rdy && data_in == SOF) state_d = S_CMD;
            S_CMD:  if (data_rdy) state_d = data_in[7] ? S_CHK : S_DATA;
            S_DATA: if (data_rdy && dcnt_q == BW'(BYTES - 1)) state_d = S_CHK;
            S_CHK:  if (data_rdy) state_d = S_RESP;
            S_RESP: if (tx_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (timeout) state_d = S_IDLE;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            rd_q       <= 1'b0;
            chk_q      <= '0;
            data_q     <= '0;
            dcnt_q     <= '0;
            tmo_q      <= '0;
            exec_q     <= 1'b0;
            ok_q       <= 1'b0;
            resp_q     <= '0;
            rem_q      <= '0;
            regs_q     <= {NUM_REGS{RESET_VAL}};
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
            upd_q      <= 1'b0;
            wr_addr_q  <= '0;
            err_q      <= '0;
        end else begin
            upd_q  <= 1'b0;
            exec_q <= 1'b0;
            tmo_q  <= (in_frame && !data_rdy && !timeout) ? tmo_q + 1'b1 : '0;
            if (err_inc && err_q != 8'hFF) err_q <= err_q + 1'b1;

            // The checksum register starts at CMD, which is also the whole read checksum.
            if (data_rdy) begin
                case (state_q)
                    S_CMD: begin
                        addr_q <= data_in[6:0];
                        rd_q   <= data_in[7];
                        chk_q  <= data_in;
                        dcnt_q <= '0;
                    end
                    S_DATA: begin
                        data_q <= WIDTH'({data_q, data_in});
                        chk_q  <= chk_q ^ data_in;
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                    S_CHK: begin
                        exec_q <= 1'b1;
                        ok_q   <= (data_in == chk_q) && addr_ok;
                    end
                    default: ;
                endcase
            end

            if (exec_q) begin
                tx_valid_q <= 1'b1;
                rem_q      <= '0;
                if (!ok_q) begin
                    tx_byte_q <= NAK;
                end else begin
                    tx_byte_q <= ACK;
                    if (rd_q) begin
                        rem_q <= BW'(BYTES);
                        for (int i = 0; i < NUM_REGS; i++)
                            if (addr_q == 7'(i)) resp_q <= regs_q[i];
                    end else begin
                        for (int i = 0; i < NUM_REGS; i++)
                            if (addr_q == 7'(i)) regs_q[i] <= data_q;
                        upd_q     <= 1'b1;
                        wr_addr_q <= addr_q;
                    end
                end
            end else if (tx_valid_q && tx_ready) begin
                if (rem_q != '0) begin
                    tx_byte_q <= resp_q[WIDTH-1 -: 8];
                    resp_q    <= resp_q << 8;
                    rem_q     <= rem_q - 1'b1;
                end else begin
                    tx_valid_q <= 1'b0;
                end
            end
        end
    end

    assign regs         = regs_q;
    assign tx_byte      = tx_byte_q;
    assign tx_valid     = tx_valid_q;
    assign update_pulse = upd_q;
    assign wr_addr      = wr_addr_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_pid_param_loader.sv
// Bench for pid_param_loader: frame-level reference model compared every cycle,
// plus directed frames with hand-computed literal expectations.
module tb_pid_param_loader;
    localparam int NUM_REGS = 4;
    localparam int WIDTH    = 16;
    localparam int TIMEOUT  = 32;
    localparam int BYTES    = WIDTH / 8;

    logic                      clk_in;
    logic                      rst;
    logic                      data_rdy;
    logic [7:0]                data_in;
    logic [7:0]                tx_byte;
    logic                      tx_valid;
    logic                      tx_ready;
    logic [NUM_REGS*WIDTH-1:0] regs;
    logic                      update_pulse;
    logic [6:0]                wr_addr;
    logic [7:0]                err_count;

    pid_param_loader #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_in(clk_in), .reset(rst), .data_rdy(data_rdy), .data_in(data_in),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .regs(regs),
        .update_pulse(update_pulse), .wr_addr(wr_addr), .err_count(err_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: collects whole frames, then judges them.
    logic [WIDTH-1:0] m_regs [NUM_REGS];
    logic [7:0]       m_err;
    logic [6:0]       m_wr;
    logic             m_upd;
    logic             m_txv;
    logic [7:0]       m_txq [$];
    logic [7:0]       fr [$];
    int               idle;
    bit               infr, busy, was_busy, pend, p_ok;
    logic [7:0]       p_cmd, x;
    logic [WIDTH-1:0] p_data;
    int               p_idx;

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        m_err = 0; m_wr = 0; m_upd = 0; m_txv = 0;
        m_txq.delete(); fr.delete();
        idle = 0; infr = 0; busy = 0; pend = 0; p_ok = 0;
    endtask

    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            was_busy = busy;
            m_upd = 0;
            if (pend) begin
                pend = 0;
                m_txv = 1;
                p_idx = int'(p_cmd[6:0]);
                if (!p_ok) begin
                    m_txq = '{8'h15};
                    if (m_err != 8'd255) m_err = m_err + 8'd1;
                end else if (p_cmd[7]) begin
                    m_txq = '{8'h06};
                    for (int b = BYTES - 1; b >= 0; b--) m_txq.push_back(m_regs[p_idx][b*8 +: 8]);
                end else begin
                    m_regs[p_idx] = p_data;
                    m_wr = p_cmd[6:0];
                    m_upd = 1;
                    m_txq = '{8'h06};
                end
            end else if (m_txv && tx_ready) begin
                void'(m_txq.pop_front());
                if (m_txq.size() == 0) begin
                    m_txv = 0;
                    busy = 0;
                end
            end
            if (!was_busy) begin
                if (!infr) begin
                    if (data_rdy && data_in == 8'hA5) begin
                        infr = 1; fr.delete(); idle = 0;
                    end
                end else if (data_rdy) begin
                    fr.push_back(data_in);
                    idle = 0;
                    if (fr.size() == (fr[0][7] ? 2 : BYTES + 2)) begin
                        x = 0;
                        for (int i = 0; i < fr.size() - 1; i++) x = x ^ fr[i];
                        p_cmd = fr[0];
                        p_data = 0;
                        if (!fr[0][7])
                            for (int i = 1; i <= BYTES; i++) p_data = WIDTH'({p_data, fr[i]});
                        p_ok = (fr[fr.size()-1] == x) && (int'(fr[0][6:0]) < NUM_REGS);
                        pend = 1; busy = 1; infr = 0;
                    end
                end else begin
                    idle++;
                    if (idle == TIMEOUT) begin
                        infr = 0;
                        if (m_err != 8'd255) m_err = m_err + 8'd1;
                    end
                end
            end
        end
    end

    function automatic logic [NUM_REGS*WIDTH-1:0] m_flat();
        logic [NUM_REGS*WIDTH-1:0] f;
        for (int i = 0; i < NUM_REGS; i++) f[i*WIDTH +: WIDTH] = m_regs[i];
        return f;
    endfunction

    logic [7:0] rxq [$];
    int upd_cnt = 0;

    always @(negedge clk_in) begin
        if (!rst) begin
            chk("regs", 64'(regs), 64'(m_flat()));
            chk("err_count", 64'(err_count), 64'(m_err));
            chk("wr_addr", 64'(wr_addr), 64'(m_wr));
            chk("update_pulse", 64'(update_pulse), 64'(m_upd));
            chk("tx_valid", 64'(tx_valid), 64'(m_txv));
            if (m_txv && m_txq.size() > 0) chk("tx_byte", 64'(tx_byte), 64'(m_txq[0]));
            if (tx_valid && tx_ready) rxq.push_back(tx_byte);
            if (update_pulse) upd_cnt++;
        end
    end

    logic [7:0] fq [$];
    logic [7:0] erx [$];

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk_in); #1; end
    endtask

    task automatic send();
        foreach (fq[i]) begin
            data_rdy = 1'b1; data_in = fq[i];
            @(posedge clk_in); #1;
        end
        data_rdy = 1'b0; data_in = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || infr || pend) && n < 200) begin
            @(posedge clk_in); #1;
            n++;
        end
        chk({name, "_wait_bound"}, 64'(n < 200), 64'd1);
        cycles(2);
    endtask

    task automatic check_rx(input string name);
        chk({name, "_count"}, 64'(rxq.size()), 64'(erx.size()));
        for (int i = 0; i < erx.size() && i < rxq.size(); i++)
            chk({name, "_byte"}, 64'(rxq[i]), 64'(erx[i]));
        rxq.delete();
    endtask

    task automatic reset_literals(input string tag);
        chk({tag, "_regs"}, 64'(regs), 64'd0);
        chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        chk({tag, "_tx_byte"}, 64'(tx_byte), 64'd0);
        chk({tag, "_update"}, 64'(update_pulse), 64'd0);
        chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        chk({tag, "_err"}, 64'(err_count), 64'd0);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #2;
        reset_literals(tag);
        @(posedge clk_in); #1;
        chk({tag, "_tx_valid_next"}, 64'(tx_valid), 64'd0);
        rst = 1'b0;
        cycles(1);
        rxq.delete();
    endtask

    initial begin
        rst = 1'b0; data_rdy = 1'b0; data_in = 8'h00; tx_ready = 1'b1;
        #2 rst = 1'b1;
        #2 reset_literals("por");
        @(posedge clk_in); #1;
        rst = 1'b0;
        cycles(2);

        // 1: write 0x1234 to reg 1
        upd_cnt = 0;
        fq = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h27}; send(); wait_idle("t1");
        erx = '{8'h06}; check_rx("t1_rx");
        chk("t1_reg1", 64'(regs[31:16]), 64'h1234);
        chk("t1_wr_addr", 64'(wr_addr), 64'd1);
        chk("t1_upd_cnt", 64'(upd_cnt), 64'd1);

        // 2: bad checksum, then out-of-range address
        fq = '{8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h00}; send(); wait_idle("t2a");
        erx = '{8'h15}; check_rx("t2a_rx");
        chk("t2a_reg2", 64'(regs[47:32]), 64'h0);
        chk("t2a_err", 64'(err_count), 64'd1);
        fq = '{8'hA5, 8'h07, 8'h00, 8'h01, 8'h06}; send(); wait_idle("t2b");
        erx = '{8'h15}; check_rx("t2b_rx");
        chk("t2b_err", 64'(err_count), 64'd2);

        // 3: read-back of reg 1 with back-pressure
        tx_ready = 1'b0;
        fq = '{8'hA5, 8'h81, 8'h81}; send();
        cycles(10);
        chk("t3_hold_valid", 64'(tx_valid), 64'd1);
        chk("t3_hold_byte", 64'(tx_byte), 64'h06);
        tx_ready = 1'b1;
        wait_idle("t3");
        erx = '{8'h06, 8'h12, 8'h34}; check_rx("t3_rx");

        // 4: inter-byte timeout, then a good frame
        fq = '{8'hA5, 8'h01, 8'h12}; send();
        cycles(TIMEOUT + 2);
        erx = '{}; check_rx("t4_no_tx");
        chk("t4_err", 64'(err_count), 64'd3);
        fq = '{8'hA5, 8'h02, 8'hBE, 8'hEF, 8'h53}; send(); wait_idle("t4b");
        erx = '{8'h06}; check_rx("t4b_rx");
        chk("t4b_reg2", 64'(regs[47:32]), 64'hBEEF);

        // 6: garbage before SOF, back-to-back; SOF value as data; top address
        fq = '{8'h00, 8'hFF, 8'h55, 8'hA5, 8'h03, 8'hCA, 8'hFE, 8'h37}; send(); wait_idle("t6a");
        erx = '{8'h06}; check_rx("t6a_rx");
        chk("t6a_reg3", 64'(regs[63:48]), 64'hCAFE);
        fq = '{8'hA5, 8'h00, 8'hA5, 8'h5A, 8'hFF}; send(); wait_idle("t6b");
        erx = '{8'h06}; check_rx("t6b_rx");
        chk("t6b_reg0", 64'(regs[15:0]), 64'hA55A);
        chk("t6_err", 64'(err_count), 64'd3);

        // 5: reset mid-frame, tail bytes must be ignored afterwards
        fq = '{8'hA5, 8'h01, 8'h12}; send();
        pulse_reset("t5a");
        fq = '{8'h34, 8'h27}; send(); cycles(4);
        erx = '{}; check_rx("t5a_tail");
        chk("t5a_regs", 64'(regs), 64'd0);

        // 5: reset while a response is pending
        tx_ready = 1'b0;
        fq = '{8'hA5, 8'h81, 8'h81}; send(); cycles(3);
        chk("t5b_pre_valid", 64'(tx_valid), 64'd1);
        pulse_reset("t5b");
        tx_ready = 1'b1;
        cycles(5);
        erx = '{}; check_rx("t5b_after");
        chk("t5b_valid", 64'(tx_valid), 64'd0);

        // error counter saturation
        for (int f = 0; f < 260; f++) begin
            fq = '{8'hA5, 8'h07, 8'h00, 8'h01, 8'h06}; send(); wait_idle("sat");
        end
        rxq.delete();
        chk("sat_err", 64'(err_count), 64'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
